// File: rtl/alu_operand_stage.sv
// EX-stage operand select with rs/rt bypass, load-use interlock and a
// single-entry valid/ready register feeding the ALU.
module alu_operand_stage #(
    parameter int DW     = 32,
    parameter int NFWD   = 2,
    parameter int BCONST = 16,
    parameter int CNTW   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         a_sel,
    input  logic [1:0]         b_sel,
    input  logic [DW-1:0]      rdata1,
    input  logic [DW-1:0]      rdata2,
    input  logic [DW-1:0]      ext,
    input  logic [NFWD-1:0]    rs_hit,
    input  logic [NFWD-1:0]    rt_hit,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_pend,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [CNTW-1:0]    stall_cnt
);

    localparam logic [DW-1:0] BCONST_W = DW'(BCONST);

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic          rs_pend;
    logic          rt_pend;
    logic          rs_used;
    logic          rt_used;
    logic          interlock;
    logic          capture;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;

    // Scan from the oldest source down so the lowest matching index wins.
    always_comb begin
        rs_val  = rdata1;
        rs_pend = 1'b0;
        rt_val  = rdata2;
        rt_pend = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (rs_hit[i]) begin
                rs_val  = fwd_data[i*DW +: DW];
                rs_pend = fwd_pend[i];
            end
            if (rt_hit[i]) begin
                rt_val  = fwd_data[i*DW +: DW];
                rt_pend = fwd_pend[i];
            end
        end
    end

    always_comb begin
        a_next = '0;
        case (a_sel)
            2'b00:   a_next = rs_val;
            2'b01:   a_next = rt_val;
            2'b10:   a_next = ext;
            default: a_next = '0;
        endcase
        b_next = '0;
        case (b_sel)
            2'b00:   b_next = rt_val;
            2'b01:   b_next = ext;
            2'b10:   b_next = '0;
            default: b_next = BCONST_W;
        endcase
    end

    assign rs_used   = (a_sel == 2'b00);
    assign rt_used   = (a_sel == 2'b01) || (b_sel == 2'b00);
    assign interlock = in_valid & ((rs_used & rs_pend) | (rt_used & rt_pend));
    assign in_ready  = !interlock & (!out_valid | out_ready) & !flush;
    assign capture   = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
                alu_a     <= a_next;
                alu_b     <= b_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Interlock cycles are counted even while a flush is in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (interlock && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: select/bypass table plus interlock,
// back-pressure, flush and async-reset sequences.
module tb_alu_operand_stage;

    localparam int DW   = 32;
    localparam int NFWD = 2;
    localparam int CNTW = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         a_sel;
    logic [1:0]         b_sel;
    logic [DW-1:0]      rdata1;
    logic [DW-1:0]      rdata2;
    logic [DW-1:0]      ext;
    logic [NFWD-1:0]    rs_hit;
    logic [NFWD-1:0]    rt_hit;
    logic [NFWD*DW-1:0] fwd_data;
    logic [NFWD-1:0]    fwd_pend;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [CNTW-1:0]    stall_cnt;

    int tests = 0;
    int fails = 0;

    alu_operand_stage #(.DW(DW), .NFWD(NFWD), .BCONST(16), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a_sel(a_sel), .b_sel(b_sel), .rdata1(rdata1), .rdata2(rdata2), .ext(ext),
        .rs_hit(rs_hit), .rt_hit(rt_hit), .fwd_data(fwd_data), .fwd_pend(fwd_pend),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] ext;
        logic [1:0]  rs_hit;
        logic [1:0]  rt_hit;
        logic [31:0] fwd0;
        logic [31:0] fwd1;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; a_sel = 2'b00; b_sel = 2'b00;
        rdata1 = '0; rdata2 = '0; ext = '0;
        rs_hit = '0; rt_hit = '0; fwd_data = '0; fwd_pend = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{2'b10, 2'b11, 32'h0, 32'h0, 32'h5, 2'b00, 2'b00, 32'h0, 32'h0, 32'h5, 32'h10};
        vecs[1] = '{2'b00, 2'b10, 32'h2, 32'h0, 32'h0, 2'b11, 2'b00, 32'hAAAA_0000, 32'h1111_1111, 32'hAAAA_0000, 32'h0};
        vecs[2] = '{2'b00, 2'b00, 32'h2, 32'h33, 32'h0, 2'b10, 2'b00, 32'h0, 32'h1111_1111, 32'h1111_1111, 32'h33};
        vecs[3] = '{2'b01, 2'b01, 32'h0, 32'h9, 32'h80, 2'b00, 2'b01, 32'h44, 32'h0, 32'h44, 32'h80};
        vecs[4] = '{2'b11, 2'b00, 32'h0, 32'h9, 32'h0, 2'b00, 2'b11, 32'h55, 32'h66, 32'h0, 32'h55};
        vecs[5] = '{2'b00, 2'b00, 32'hDEAD_BEEF, 32'h9, 32'h0, 2'b00, 2'b10, 32'h1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[6] = '{2'b10, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h10};

        idle_inputs();
        resetn = 1'b0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_alu_a", 64'(alu_a), 64'd0);
        check("reset_alu_b", 64'(alu_b), 64'd0);
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        #5 resetn = 1'b1;
        step();

        // Back-to-back captures with out_ready=1: one per cycle
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            a_sel = vecs[i].a_sel; b_sel = vecs[i].b_sel;
            rdata1 = vecs[i].rdata1; rdata2 = vecs[i].rdata2; ext = vecs[i].ext;
            rs_hit = vecs[i].rs_hit; rt_hit = vecs[i].rt_hit;
            fwd_data = {vecs[i].fwd1, vecs[i].fwd0};
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            step();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_alu_a", i), 64'(alu_a), 64'(vecs[i].exp_a));
            check($sformatf("vec%0d_alu_b", i), 64'(alu_b), 64'(vecs[i].exp_b));
        end
        idle_inputs();
        step();
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Load-use interlock on rt from source 1
        in_valid = 1'b1; a_sel = 2'b10; b_sel = 2'b00;
        rt_hit = 2'b10; fwd_pend = 2'b10; fwd_data = {32'h0, 32'h5};
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("interlock%0d_in_ready", i), 64'(in_ready), 64'd0);
            step();
            check($sformatf("interlock%0d_out_valid", i), 64'(out_valid), 64'd0);
        end
        check("interlock_stall_cnt", 64'(stall_cnt), 64'd3);
        fwd_pend = 2'b00; fwd_data = {32'h77, 32'h5};
        #1;
        check("unpend_in_ready", 64'(in_ready), 64'd1);
        step();
        check("unpend_out_valid", 64'(out_valid), 64'd1);
        check("unpend_alu_b", 64'(alu_b), 64'h77);
        check("unpend_stall_cnt", 64'(stall_cnt), 64'd3);

        // Pending value on an operand that is not used
        a_sel = 2'b10; b_sel = 2'b01; ext = 32'h99;
        rs_hit = 2'b01; rt_hit = 2'b00; fwd_pend = 2'b01;
        #1;
        check("unused_in_ready", 64'(in_ready), 64'd1);
        step();
        check("unused_stall_cnt", 64'(stall_cnt), 64'd3);
        check("unused_alu_a", 64'(alu_a), 64'h99);
        check("unused_alu_b", 64'(alu_b), 64'h99);

        // Back-pressure then flush
        out_ready = 1'b0; fwd_pend = 2'b00; rs_hit = 2'b00;
        a_sel = 2'b10; b_sel = 2'b10; ext = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
            step();
            check($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_alu_a", i), 64'(alu_a), 64'h99);
            check($sformatf("bp%0d_alu_b", i), 64'(alu_b), 64'h99);
        end
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_alu_a_no_capture", 64'(alu_a), 64'h99);

        // Two interlock cycles (second one under flush), then capture -> stall_cnt=5
        in_valid = 1'b1; a_sel = 2'b00; b_sel = 2'b10;
        rs_hit = 2'b01; fwd_pend = 2'b01; fwd_data = {32'h0, 32'hCAFE};
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_interlock_stall_cnt", 64'(stall_cnt), 64'd5);
        check("flush_interlock_out_valid", 64'(out_valid), 64'd0);
        fwd_pend = 2'b00;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        check("pre_reset_alu_a", 64'(alu_a), 64'hCAFE);
        check("pre_reset_stall_cnt", 64'(stall_cnt), 64'd5);

        // Asynchronous reset between edges
        #2 resetn = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_alu_a", 64'(alu_a), 64'd0);
        check("async_alu_b", 64'(alu_b), 64'd0);
        check("async_stall_cnt", 64'(stall_cnt), 64'd0);
        #3 resetn = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; a_sel = 2'b10; b_sel = 2'b11; ext = 32'h3;
        rs_hit = 2'b00;
        step();
        check("post_reset_out_valid", 64'(out_valid), 64'd1);
        check("post_reset_alu_a", 64'(alu_a), 64'h3);
        check("post_reset_alu_b", 64'(alu_b), 64'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
